huffman_phase_sequencer: RTL and testbench
==========================================

// Module: huffman_phase_sequencer
// PURPOSE
//  Top-level sequencer of the Huffman encoder. Runs four engines strictly in order:
//  count -> tree_construct -> codegen -> encode, using start/finish handshakes.
//  Applies a per-phase watchdog and reports busy/done/error to the host.
//  Sits between the host interface and the datapath engines; holds no symbol data.
// PARAMETERS
//  TIMEOUT_CYC  4096  max cycles one phase may run before error; min 2
//  TMR_W        13    watchdog counter width; must satisfy 2**TMR_W > TIMEOUT_CYC
// PORTS
//  clk               in   1      system clock, rising edge
//  reset             in   1      synchronous, active-low reset
//  go                in   1      host request; sampled in IDLE only
//  abort             in   1      host abort; any state except IDLE
//  count_finish      in   1      frequency counter done (curr_count valid)
//  build_tree_finish in   1      tree_construct done (array valid)
//  codegen_finish    in   1      code table generator done
//  encode_finish     in   1      bitstream encoder done
//  count_start       out  1      level; high for whole COUNT phase
//  build_tree_start  out  1      level; high for whole BUILD phase
//  codegen_start     out  1      level; high for whole CODEGEN phase
//  encode_start      out  1      level; high for whole ENCODE phase
//  busy              out  1      high in COUNT..ENCODE
//  done              out  1      one-cycle pulse on ENCODE completion
//  error             out  1      sticky; high in ERR state
//  err_phase         out  2      phase that timed out (0 cnt,1 tree,2 cgen,3 enc)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE; all outputs 0; timer 0.
//  - States: IDLE, COUNT, BUILD, CODEGEN, ENCODE, ERR (all transitions registered).
//  - IDLE: go==1 -> COUNT next cycle; count_start high from that cycle.
//  - Each phase X: X_start = (state==X). Its finish==1 -> next phase; start drops and next
//    start rises on the same edge (no idle gap, no overlap). Finish from engines of other
//    phases is ignored.
//  - ENCODE + encode_finish -> IDLE; done pulses in the first IDLE cycle (registered, 1 cyc).
//  - Watchdog: timer clears on every phase entry, +1 per cycle in phase. Timer reaching
//    TIMEOUT_CYC-1 with finish still low -> ERR; err_phase latched. Finish on that same
//    cycle wins (advance, no error).
//  - ERR: all *_start 0, busy 0, error 1. Leaves only by go==0 and abort==1 together
//    -> IDLE, error and err_phase cleared.
//  - abort==1 in COUNT..ENCODE -> IDLE next cycle, no done, no error; abort beats finish
//    and timeout on the same cycle. abort in IDLE: no effect.
//  - go held high past done restarts a new run (IDLE->COUNT one cycle after done pulse).
//  - reset mid-phase: immediate return to reset values at that edge; engines are reset
//    by the same reset, so no drain is needed.
//  - Latency: go -> count_start = 1 cycle; X_finish -> next start = 1 cycle.
// STRUCTURE
//  - huffman_pkg: typedef enum logic [2:0] seq_state_t; typedef logic [1:0] phase_t with
//    PH_COUNT/PH_TREE/PH_CGEN/PH_ENC; NUM_SYMBOLS=128, CNT_W=16, TREE_NODES=534.
//  - Sub-module phase_watchdog (clear, enable, expired; params TIMEOUT_CYC, TMR_W).
//  - FSM: one always_ff for state/err_phase/done; one always_comb for next state;
//    outputs decoded from state.
// TESTING
//  1 Nominal: go=1 for 1 cyc; finishes 5/40/20/60 cycles after each start -> starts in
//    order, never two high together, busy high 125+ cyc, exactly one done pulse.
//  2 Timeout: TIMEOUT_CYC=16, build_tree_finish never asserted -> error=1, err_phase=1
//    16 cyc after build_tree_start rose; all starts 0; abort=1,go=0 -> IDLE, error=0.
//  3 Race: codegen_finish on exactly the expiry cycle -> ENCODE entered, error stays 0.
//  4 Abort: abort=1 in ENCODE together with encode_finish -> IDLE, done never pulses.
//  5 Stray finish: encode_finish=1 during COUNT -> ignored; reset=0 mid-BUILD -> all 0
//    next cycle, go=1 then restarts at COUNT.
//  6 Back-to-back: go held 1 -> second count_start rises 1 cycle after done pulse.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman encoder: sequencer state encoding,
// phase identifiers and the datapath sizing constants used by the engines.
package huffman_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COUNT   = 3'd1,
    ST_BUILD   = 3'd2,
    ST_CODEGEN = 3'd3,
    ST_ENCODE  = 3'd4,
    ST_ERR     = 3'd5
  } seq_state_t;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_COUNT = 2'd0;
  localparam phase_t PH_TREE  = 2'd1;
  localparam phase_t PH_CGEN  = 2'd2;
  localparam phase_t PH_ENC   = 2'd3;

  localparam int NUM_PHASES  = 4;
  localparam int NUM_SYMBOLS = 128;
  localparam int CNT_W       = 16;
  localparam int TREE_NODES  = 534;

  // Engine phase -> sequencer state that runs it.
  function automatic seq_state_t phase_state(input phase_t ph);
    seq_state_t st;
    case (ph)
      PH_COUNT: st = ST_COUNT;
      PH_TREE:  st = ST_BUILD;
      PH_CGEN:  st = ST_CODEGEN;
      default:  st = ST_ENCODE;
    endcase
    return st;
  endfunction

  // Sequencer state -> phase id reported on a timeout.
  function automatic phase_t state_phase(input seq_state_t st);
    phase_t ph;
    case (st)
      ST_BUILD:   ph = PH_TREE;
      ST_CODEGEN: ph = PH_CGEN;
      ST_ENCODE:  ph = PH_ENC;
      default:    ph = PH_COUNT;
    endcase
    return ph;
  endfunction

  // Successor of a running phase; ENCODE completes back to IDLE.
  function automatic seq_state_t next_phase(input seq_state_t st);
    seq_state_t nx;
    case (st)
      ST_COUNT:   nx = ST_BUILD;
      ST_BUILD:   nx = ST_CODEGEN;
      ST_CODEGEN: nx = ST_ENCODE;
      default:    nx = ST_IDLE;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/huffman_phase_sequencer_if.sv
// Host and engine handshake bundle of the phase sequencer. The sequencer uses the
// slave view; the host/engine side (or a testbench) uses the master view.
interface huffman_phase_sequencer_if;
  import huffman_pkg::*;

  logic   go;
  logic   abort;
  logic   count_finish;
  logic   build_tree_finish;
  logic   codegen_finish;
  logic   encode_finish;
  logic   count_start;
  logic   build_tree_start;
  logic   codegen_start;
  logic   encode_start;
  logic   busy;
  logic   done;
  logic   error;
  phase_t err_phase;

  modport master (
    output go, abort,
    output count_finish, build_tree_finish, codegen_finish, encode_finish,
    input  count_start, build_tree_start, codegen_start, encode_start,
    input  busy, done, error, err_phase
  );

  modport slave (
    input  go, abort,
    input  count_finish, build_tree_finish, codegen_finish, encode_finish,
    output count_start, build_tree_start, codegen_start, encode_start,
    output busy, done, error, err_phase
  );

endinterface

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter: cleared on phase entry, counts while enabled and flags
// expiry on the last allowed cycle of a phase.
module phase_watchdog #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TMR_W       = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TMR_W-1:0] LAST_CYC = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             at_limit;

  assign at_limit  = (timer_q == LAST_CYC);
  assign expired_o = enable_i && at_limit;

  // Saturate at the limit so a phase stalled by its own finish race cannot wrap.
  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (enable_i && !at_limit) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/huffman_phase_sequencer.sv
// Top-level Huffman encoder sequencer: walks count -> tree -> codegen -> encode via
// level start / pulse finish handshakes, with a per-phase watchdog and host abort.
module huffman_phase_sequencer
  import huffman_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TMR_W       = 13
) (
  input  logic                       clk,
  input  logic                       reset,
  huffman_phase_sequencer_if.slave   host
);

  seq_state_t state_q;
  seq_state_t state_d;
  phase_t     err_phase_q;
  phase_t     err_phase_d;
  logic       done_q;
  logic       done_d;

  logic [NUM_PHASES-1:0] finish_vec;
  logic [NUM_PHASES-1:0] phase_active;
  logic                  in_phase;
  logic                  cur_finish;
  logic                  wd_clear;
  logic                  wd_expired;

  assign finish_vec = {host.encode_finish, host.codegen_finish,
                       host.build_tree_finish, host.count_finish};

  for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
    assign phase_active[gi] = (state_q == phase_state(phase_t'(gi)));
  end

  // Only the running phase's own finish is honoured; the others are masked off.
  assign in_phase   = |phase_active;
  assign cur_finish = |(phase_active & finish_vec);
  assign wd_clear   = (state_d != state_q);

  phase_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (in_phase),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      err_phase_q <= PH_COUNT;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_phase_q <= err_phase_d;
      done_q      <= done_d;
    end
  end

  // Priority inside a phase: abort, then own finish, then watchdog expiry.
  always_comb begin
    state_d     = state_q;
    err_phase_d = err_phase_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (host.go) begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT, ST_BUILD, ST_CODEGEN, ST_ENCODE: begin
        if (host.abort) begin
          state_d = ST_IDLE;
        end else if (cur_finish) begin
          state_d = next_phase(state_q);
          done_d  = (state_q == ST_ENCODE);
        end else if (wd_expired) begin
          state_d     = ST_ERR;
          err_phase_d = state_phase(state_q);
        end
      end
      ST_ERR: begin
        if (!host.go && host.abort) begin
          state_d     = ST_IDLE;
          err_phase_d = PH_COUNT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        err_phase_d = PH_COUNT;
      end
    endcase
  end

  always_comb begin
    host.count_start      = phase_active[PH_COUNT];
    host.build_tree_start = phase_active[PH_TREE];
    host.codegen_start    = phase_active[PH_CGEN];
    host.encode_start     = phase_active[PH_ENC];
    host.busy             = in_phase;
    host.done             = done_q;
    host.error            = (state_q == ST_ERR);
    host.err_phase        = err_phase_q;
  end

endmodule

// File: tb/tb_huffman_phase_sequencer.sv
// Directed bench for the phase sequencer: stimulus queues the expected output-vector
// changes with their cycle, a negedge monitor pops and compares each observed change.
module tb_huffman_phase_sequencer;

  localparam int TO    = 64;
  localparam int TMR_W = 7;

  // v[8..5] = count/build/codegen/encode start, v[4] busy, v[3] done, v[2] error, v[1:0] err_phase
  localparam logic [8:0] V_IDLE = 9'h000;
  localparam logic [8:0] V_CNT  = 9'h110;
  localparam logic [8:0] V_TREE = 9'h090;
  localparam logic [8:0] V_CGEN = 9'h050;
  localparam logic [8:0] V_ENC  = 9'h030;
  localparam logic [8:0] V_DONE = 9'h008;
  localparam logic [8:0] V_ERR  = 9'h004;

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   armed = 1'b0;
  bit   first = 1'b1;
  logic [8:0] prev_v;
  logic [8:0] cur_v;
  exp_t exp_q[$];
  exp_t e;

  huffman_phase_sequencer_if bus();

  huffman_phase_sequencer #(
    .TIMEOUT_CYC (TO),
    .TMR_W       (TMR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .host  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int c, input logic [8:0] v);
    exp_t x;
    x.cyc = c;
    x.v   = v;
    exp_q.push_back(x);
  endtask

  task automatic set_fin(input int which, input logic val);
    case (which)
      0:       bus.count_finish      = val;
      1:       bus.build_tree_finish = val;
      2:       bus.codegen_finish    = val;
      default: bus.encode_finish     = val;
    endcase
  endtask

  // Finish arrives dly cycles after the phase's start rose.
  task automatic run_phase(input int dly, input int which, input logic [8:0] nextv);
    repeat (dly - 1) step();
    set_fin(which, 1'b1);
    push(cyc + 1, nextv);
    step();
    set_fin(which, 1'b0);
  endtask

  task automatic start_run();
    bus.go = 1'b1;
    push(cyc + 1, V_CNT);
    step();
    bus.go = 1'b0;
  endtask

  task automatic abort_now();
    bus.abort = 1'b1;
    push(cyc + 1, V_IDLE);
    step();
    bus.abort = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cur_v = {bus.count_start, bus.build_tree_start, bus.codegen_start, bus.encode_start,
               bus.busy, bus.done, bus.error, bus.err_phase};
      if (first) begin
        n_checks++;
        if (cur_v !== V_IDLE) begin
          n_fail++;
          $display("FAIL reset_state cyc=%0d actual=%h required=%h", cyc, cur_v, V_IDLE);
        end
        first  = 1'b0;
        prev_v = cur_v;
      end else if (cur_v !== prev_v) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d actual=%h required=%h", cyc, cur_v, prev_v);
        end else begin
          e = exp_q.pop_front();
          if (cur_v !== e.v || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL output_event actual=%h@cyc%0d required=%h@cyc%0d",
                     cur_v, cyc, e.v, e.cyc);
          end
        end
        prev_v = cur_v;
      end
    end
  end

  initial begin
    reset                 = 1'b0;
    bus.go                = 1'b0;
    bus.abort             = 1'b0;
    bus.count_finish      = 1'b0;
    bus.build_tree_finish = 1'b0;
    bus.codegen_finish    = 1'b0;
    bus.encode_finish     = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    armed = 1'b1;
    step();

    // Nominal run: 5/40/20/60 cycle phases, single done pulse.
    start_run();
    run_phase(5, 0, V_TREE);
    run_phase(40, 1, V_CGEN);
    run_phase(20, 2, V_ENC);
    run_phase(60, 3, V_DONE);
    push(cyc + 1, V_IDLE);
    repeat (3) step();

    // BUILD timeout; go+abort together must not leave ERR, abort alone does.
    start_run();
    run_phase(3, 0, V_TREE);
    push(cyc + TO, V_ERR | 9'd1);
    repeat (TO + 4) step();
    bus.go    = 1'b1;
    bus.abort = 1'b1;
    repeat (2) step();
    bus.go = 1'b0;
    push(cyc + 1, V_IDLE);
    step();
    bus.abort = 1'b0;
    step();

    // ENCODE timeout reports phase 3.
    start_run();
    run_phase(2, 0, V_TREE);
    run_phase(2, 1, V_CGEN);
    run_phase(2, 2, V_ENC);
    push(cyc + TO, V_ERR | 9'd3);
    repeat (TO + 2) step();
    abort_now();

    // Codegen finish on the expiry cycle wins over the watchdog.
    start_run();
    run_phase(2, 0, V_TREE);
    run_phase(2, 1, V_CGEN);
    run_phase(TO, 2, V_ENC);
    run_phase(3, 3, V_DONE);
    push(cyc + 1, V_IDLE);
    repeat (2) step();

    // Abort together with encode_finish: back to IDLE, no done.
    start_run();
    run_phase(2, 0, V_TREE);
    run_phase(2, 1, V_CGEN);
    run_phase(2, 2, V_ENC);
    step();
    bus.abort         = 1'b1;
    bus.encode_finish = 1'b1;
    push(cyc + 1, V_IDLE);
    step();
    bus.abort         = 1'b0;
    bus.encode_finish = 1'b0;
    step();

    // Abort on the COUNT expiry cycle beats the timeout.
    start_run();
    repeat (TO - 1) step();
    abort_now();

    // Abort while IDLE is ignored.
    bus.abort = 1'b1;
    repeat (3) step();
    bus.abort = 1'b0;
    step();

    // Stray finishes from other phases during COUNT, then reset mid-BUILD.
    start_run();
    bus.encode_finish  = 1'b1;
    bus.codegen_finish = 1'b1;
    repeat (3) step();
    bus.encode_finish  = 1'b0;
    bus.codegen_finish = 1'b0;
    run_phase(3, 0, V_TREE);
    repeat (3) step();
    reset = 1'b0;
    push(cyc + 1, V_IDLE);
    step();
    reset = 1'b1;
    step();
    start_run();
    run_phase(4, 0, V_TREE);
    abort_now();

    // Back-to-back runs with go held high.
    bus.go = 1'b1;
    push(cyc + 1, V_CNT);
    step();
    run_phase(2, 0, V_TREE);
    run_phase(2, 1, V_CGEN);
    run_phase(2, 2, V_ENC);
    run_phase(2, 3, V_DONE);
    push(cyc + 1, V_CNT);
    step();
    bus.go = 1'b0;
    run_phase(2, 0, V_TREE);
    abort_now();

    repeat (5) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
